// File: rtl/dlx_pkg.sv
// Shared DLX definitions: word type, opcode field, fetch FSM states and fixed encodings.
package dlx_pkg;
  typedef logic [0:31] word_t;

  localparam int OPC_MSB = 0;
  localparam int OPC_LSB = 5;

  localparam logic [0:5] TRAP_OPC_DEFAULT = 6'h11;
  localparam word_t      NOP_WORD_DEFAULT = 32'h5400_0000;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} fetch_state_t;

  function automatic logic [0:5] opcode_of(input word_t w);
    return w[OPC_MSB:OPC_LSB];
  endfunction
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline latch. Priority: reset > bubble > load > hold.
module if_id_reg
  import dlx_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP_WORD_DEFAULT
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  bubble,
  input  word_t instr,
  input  word_t pc_plus4,
  output word_t q_instr,
  output word_t q_pc_plus4,
  output logic  q_valid
);
  always_ff @(posedge clk) begin
    if (reset) begin
      q_instr    <= NOP_INSTR;
      q_pc_plus4 <= '0;
      q_valid    <= 1'b0;
    end else if (bubble) begin
      // pc_plus4 is meaningless for a bubble, so it is left holding.
      q_instr <= NOP_INSTR;
      q_valid <= 1'b0;
    end else if (load) begin
      q_instr    <= instr;
      q_pc_plus4 <= pc_plus4;
      q_valid    <= 1'b1;
    end
  end
endmodule

// File: rtl/if_fetch_stage.sv
// DLX instruction-fetch stage: PC, RUN/HALT trap FSM, IF/ID latch.
// Optional counters perf_fetched/perf_stalls when FETCH_PERF_CNT_EN is defined.
module if_fetch_stage
  import dlx_pkg::*;
#(
  parameter word_t      RESET_PC    = 32'h0000_0000,
  parameter word_t      NOP_INSTR   = NOP_WORD_DEFAULT,
  parameter logic [0:5] TRAP_OPCODE = TRAP_OPC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [0:31] imem_addr,
  input  logic [0:31] imem_out,
  input  logic        stall,
  input  logic        redirect,
  input  logic [0:31] redirect_target,
  output logic [0:31] if_id_instr,
  output logic [0:31] if_id_pc_plus4,
  output logic        if_id_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [0:31] perf_fetched,
  output logic [0:31] perf_stalls,
`endif
  output logic        fetch_halted
);
  // Handshake: no valid/ready; stall holds everything, redirect overrides stall.
  fetch_state_t state, state_next;
  word_t        pc, pc_next, pc_plus4;
  logic         load, bubble;

  assign imem_addr    = pc;
  assign pc_plus4     = pc + 32'd4;
  // State register doubles as the observable FSM state.
  assign fetch_halted = (state == HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    load       = 1'b0;
    bubble     = 1'b0;
    if (redirect) begin
      pc_next    = {redirect_target[0:29], 2'b00};
      bubble     = 1'b1;
      state_next = RUN;
    end else if (!stall) begin
      case (state)
        RUN: begin
          load = 1'b1;
          if (opcode_of(imem_out) == TRAP_OPCODE) state_next = HALT;
          else                                    pc_next    = pc_plus4;
        end
        HALT:    bubble = 1'b1;
        default: bubble = 1'b1;
      endcase
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .bubble     (bubble),
    .instr      (imem_out),
    .pc_plus4   (pc_plus4),
    .q_instr    (if_id_instr),
    .q_pc_plus4 (if_id_pc_plus4),
    .q_valid    (if_id_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stalls  <= '0;
    end else if (state != HALT) begin
      if (load && perf_fetched != 32'hFFFF_FFFF)
        perf_fetched <= perf_fetched + 32'd1;
      if (stall && !redirect && perf_stalls != 32'hFFFF_FFFF)
        perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage DLX pipeline.
- Owns the PC, drives the instruction-memory address and registers the fetched word into the IF/ID latch.
- Feeds the decode stage directly.
- Detects a fetched TRAP and halts fetch, so the trap is the last valid instruction to reach `trap_mem`.
- Honours stall requests from hazard detection and redirect requests from branch/jump resolution.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h5400_0000, bubble word injected into IF/ID.
- TRAP_OPCODE, 6'h11, value of instruction bits [0:5] identifying TRAP.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous reset, active-high.
- imem_addr  out  [0:31]  instruction-memory byte address; equals the current PC.
- imem_out  in  [0:31]  instruction word at imem_addr, combinational read, valid the same cycle.
- stall  in  1  hold PC and IF/ID (load-use hazard from decode).
- redirect  in  1  taken branch/jump resolved downstream; squash and refetch.
- redirect_target  in  [0:31]  new PC when redirect=1.
- if_id_instr  out  [0:31]  registered instruction to decode.
- if_id_pc_plus4  out  [0:31]  registered PC+4 of that instruction (link/branch base).
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- fetch_halted  out  1  fetch frozen after a TRAP.

Behaviour:
- Reset (synchronous, active-high; clock named clk, reset named reset):
  - PC <= RESET_PC.
  - if_id_instr <= NOP_INSTR, if_id_pc_plus4 <= 0, if_id_valid <= 0.
  - State <= RUN, fetch_halted <= 0.
  - Reset asserted mid-halt or mid-stall fully restarts the stage.
- imem_addr = PC at all times, combinational from the PC register.
- FSM states: RUN and HALT. Per-edge priority is reset > redirect > stall > normal.
- redirect=1, in any state and even when stall=1:
  - PC <= {redirect_target[0:29], 2'b00}; the low two bits are forced to 0.
  - IF/ID <= NOP_INSTR, valid 0.
  - State <= RUN. This cancels a HALT caused by a wrong-path TRAP.
- stall=1 and redirect=0: PC, IF/ID and state all hold unchanged.
- RUN, no stall/redirect:
  - IF/ID <= {imem_out, PC+4, valid 1}.
  - If imem_out[0:5]==TRAP_OPCODE: PC holds and state <= HALT. Otherwise PC <= PC+4.
- HALT, no redirect:
  - PC holds.
  - IF/ID <= NOP_INSTR, valid 0.
  - fetch_halted=1, registered in the same edge that enters HALT.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. Bit 0 is the MSB throughout.
- Latency: an instruction appears in IF/ID one clk after its address is presented. Redirect costs one bubble, visible the cycle after redirect.
- Unknown imem_out (X) is latched as-is; TRAP detection on X is don't-care.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_fetched [0:31] (count of edges loading valid=1 into IF/ID).
  - Adds perf_stalls [0:31] (count of edges with stall=1 and redirect=0).
  - Both counters clear on reset, saturate at 32'hFFFF_FFFF, and are frozen while in HALT.
- When undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package dlx_pkg:
  - TRAP_OPCODE and NOP_INSTR constants.
  - Opcode field slice constants ([0:5]).
  - Fetch state enum {RUN, HALT}.
  - 32-bit word typedef.
- One sub-module, if_id_reg: holds instr/pc_plus4/valid with load, hold and bubble controls. The FSM and PC logic stay in if_fetch_stage.

Test Plan:
- Straight-line: reset, then release with imem words A,B,C at 0,4,8.
  - Expected: imem_addr 0→4→8→C.
  - Expected IF/ID: (A,4,1), (B,8,1), (C,C,1).
- Stall: assert stall for 2 cycles while PC=8.
  - Expected: imem_addr stays 8; IF/ID stays (B,8,1); the stall counter reads 2 when the macro is on.
- Redirect: redirect=1, target=32'h0000_0043, at PC=C.
  - Expected: next imem_addr 0x40; IF/ID=(NOP,x,0).
  - Expected: the following cycle latches mem[0x40] with pc_plus4 0x44.
- Trap: word 32'h4400_0300 at 0x10.
  - Expected: IF/ID=(trap,0x14,1); fetch_halted=1; PC frozen at 0x10.
  - Expected: subsequent IF/ID are NOP with valid 0 for 5 cycles.
- Halt cancel and reset: in HALT, pulse redirect to 0x20.
  - Expected: state RUN and fetch resumes at 0x20.
  - Then assert reset for one cycle: PC=RESET_PC, valid=0, fetch_halted=0.
